// File: rtl/l2_cache_writeback_queue_pkg.sv
// Shared L2 writeback types: line address {tag,set} and line data.
package l2_cache_writeback_queue_pkg;

    localparam int NUM_SETS        = 256;
    localparam int SET_INDEX_WIDTH = $clog2(NUM_SETS);
    localparam int TAG_WIDTH       = 18;
    localparam int LINE_BITS       = 512;
    localparam int ADDR_WIDTH      = TAG_WIDTH + SET_INDEX_WIDTH;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]       tag;
        logic [SET_INDEX_WIDTH-1:0] set_idx;
    } l2_line_addr_t;

    typedef logic [LINE_BITS-1:0] cache_line_data_t;

endpackage

// File: rtl/l2_cache_writeback_queue_match.sv
// Combinational {set,tag} compare against all queue entries (the l2_wb_match block).
// Returns a one-hot vector marking only the youngest valid match, searched back from tail.
module l2_cache_writeback_queue_match
    import l2_cache_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  l2_line_addr_t    key,
    input  l2_line_addr_t    entry_addr [DEPTH],
    input  logic [DEPTH-1:0] entry_valid,
    input  logic [PTR_W-1:0] tail,
    output logic [DEPTH-1:0] hit_vec,
    output logic             hit
);

    // k=1 is the most recently written slot, k=DEPTH the oldest.
    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!hit && entry_valid[tail - PTR_W'(k)] && (entry_addr[tail - PTR_W'(k)] == key)) begin
                hit_vec[tail - PTR_W'(k)] = 1'b1;
                hit                       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_cache_writeback_queue.sv
// Writeback queue for dirty L2 victims with registered snoop; head outputs driven straight from storage.
// Optional L2_WB_COALESCE_EN merges a victim into a queued entry with the same {set,tag}.
module l2_cache_writeback_queue
    import l2_cache_writeback_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int ALMOST_FULL_GAP = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       evict_en,
    input  logic                       evict_dirty,
    input  logic [SET_INDEX_WIDTH-1:0] evict_set,
    input  logic [TAG_WIDTH-1:0]       evict_tag,
    input  logic [LINE_BITS-1:0]       evict_data,
    output logic                       almost_full,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [ADDR_WIDTH-1:0]      wb_addr,
    output logic [LINE_BITS-1:0]       wb_data,
    input  logic                       lookup_en,
    input  logic [SET_INDEX_WIDTH-1:0] lookup_set,
    input  logic [TAG_WIDTH-1:0]       lookup_tag,
    output logic                       lookup_hit,
    output logic [LINE_BITS-1:0]       lookup_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(ALMOST_FULL_GAP);

    l2_line_addr_t    addr_q [DEPTH];
    cache_line_data_t data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, next_valid;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, next_count;

    l2_line_addr_t    evict_addr, lookup_addr;
    logic             full, pop, push_req, push, drop, coal_wr;
    logic [DEPTH-1:0] coal_vec;

    assign evict_addr  = {evict_tag, evict_set};
    assign lookup_addr = {lookup_tag, lookup_set};

    assign full     = (count_q == DEPTH_C);
    assign wb_valid = (count_q != '0);
    assign pop      = wb_valid && wb_ready;
    assign push_req = evict_en && evict_dirty;

`ifdef L2_WB_COALESCE_EN
    logic coal_match;

    l2_cache_writeback_queue_match #(.DEPTH(DEPTH)) u_coal_match (
        .key         (evict_addr),
        .entry_addr  (addr_q),
        .entry_valid (valid_q),
        .tail        (tail_q),
        .hit_vec     (coal_vec),
        .hit         (coal_match)
    );

    // A head leaving this cycle cannot absorb new data; allocate a fresh entry instead.
    assign coal_wr = push_req && coal_match && !(pop && coal_vec[head_q]);
`else
    assign coal_vec = '0;
    assign coal_wr  = 1'b0;
`endif

    assign push = push_req && !coal_wr && (!full || pop);
    assign drop = push_req && !coal_wr && full && !pop;

    always_comb begin
        next_count = count_q;
        if (push && !pop) begin
            next_count = count_q + 1'b1;
        end else if (!push && pop) begin
            next_count = count_q - 1'b1;
        end
    end

    // At full with push+pop head==tail, so the set must follow the clear.
    always_comb begin
        next_valid = valid_q;
        if (pop) begin
            next_valid[head_q] = 1'b0;
        end
        if (push) begin
            next_valid[tail_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            almost_full <= 1'b0;
        end else begin
            count_q     <= next_count;
            valid_q     <= next_valid;
            almost_full <= (DEPTH_C - next_count) <= GAP_C;
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= evict_addr;
            data_q[tail_q] <= evict_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (coal_wr && coal_vec[i]) begin
                data_q[i] <= evict_data;
            end
        end
    end

    assign wb_addr = addr_q[head_q];
    assign wb_data = data_q[head_q];

    logic [DEPTH-1:0] snoop_vec;
    logic             snoop_hit, bypass;
    cache_line_data_t snoop_data;

    l2_cache_writeback_queue_match #(.DEPTH(DEPTH)) u_snoop_match (
        .key         (lookup_addr),
        .entry_addr  (addr_q),
        .entry_valid (valid_q),
        .tail        (tail_q),
        .hit_vec     (snoop_vec),
        .hit         (snoop_hit)
    );

    // The victim being written this cycle is younger than anything stored.
    assign bypass = (push || coal_wr) && (evict_addr == lookup_addr);

    always_comb begin
        snoop_data = evict_data;
        if (!bypass) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (snoop_vec[i]) begin
                    snoop_data = data_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookup_hit <= 1'b0;
        end else begin
            lookup_hit <= lookup_en && (bypass || snoop_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (lookup_en && (bypass || snoop_hit)) begin
            lookup_data <= snoop_data;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!drop) else $error("writeback queue: enqueue while full, victim dropped");
        end
    end

endmodule
